// File: rtl/fir_ntap_prog.sv
// fir_ntap_prog: N-tap transposed-form FIR with programmable coefficients, rounding, saturation and flush
module fir_ntap_prog #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int NTAPS  = 3,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic signed [DATA_W-1:0]   x,
  input  logic                       flush,
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  output logic                       out_valid,
  output logic signed [OUT_W-1:0]    y,
  output logic                       out_sat
);
  localparam int ACC_W = DATA_W + COEF_W + $clog2(NTAPS);
  localparam int WW = ACC_W + OUT_W + 1;
  localparam logic signed [WW-1:0] HALF = (WW'(1) << SHIFT) >> 1;
  localparam logic signed [WW-1:0] MAXV = {{(WW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [WW-1:0] MINV = {{(WW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  logic signed [COEF_W-1:0] h_q [NTAPS];
  logic signed [ACC_W-1:0]  s_q [NTAPS-1];
  logic signed [ACC_W-1:0]  hx [NTAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [WW-1:0]     sh;
  logic signed [OUT_W-1:0]  y_d, y_q;
  logic                     sat_hi, sat_lo, sat_d, sat_q, out_valid_q;
  // products at full accumulator width, round, shift and clamp the newest sum
  always_comb begin
    for (int k = 0; k < NTAPS; k++) hx[k] = ACC_W'(h_q[k]) * ACC_W'(x);
    acc = hx[0] + s_q[0];
    sh = (WW'(acc) + HALF) >>> SHIFT;
    sat_hi = sh > MAXV;
    sat_lo = sh < MINV;
    y_d = sat_hi ? MAXV[OUT_W-1:0] : sat_lo ? MINV[OUT_W-1:0] : sh[OUT_W-1:0];
    sat_d = sat_hi | sat_lo;
  end
  // coefficient writes, delay-line advance on accepted samples, registered result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NTAPS; k++) h_q[k] <= '0;
      for (int k = 0; k < NTAPS-1; k++) s_q[k] <= '0;
      y_q <= '0;
      sat_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (coef_we && int'(coef_addr) < NTAPS) h_q[coef_addr] <= coef_data;
      out_valid_q <= in_valid && !flush;
      if (flush) begin
        for (int k = 0; k < NTAPS-1; k++) s_q[k] <= '0;
      end else if (in_valid) begin
        for (int k = 0; k < NTAPS-2; k++) s_q[k] <= hx[k+1] + s_q[k+1];
        s_q[NTAPS-2] <= hx[NTAPS-1];
        y_q <= y_d;
        sat_q <= sat_d;
      end
    end
  end
  assign out_valid = out_valid_q;
  assign y = y_q;
  assign out_sat = sat_q;
endmodule

// File: doc/fir_ntap_prog.md
Name: fir_ntap_prog

Overview:
- Parametrised N-tap transposed-form FIR filter with runtime-programmable signed coefficients.
- Adds sample-valid qualification, a coefficient write port, output scaling with rounding, saturation, and delay-line flush.
- Successor to the fixed 3-tap averaging filter; drops into the same streaming datapath between the sample source and downstream DSP stages.

Parameters:
- DATA_W, 8, signed input sample width
- COEF_W, 8, signed coefficient width
- NTAPS, 3, number of taps (>=2)
- OUT_W, 16, signed output width
- SHIFT, 0, arithmetic right shift applied to the accumulator before saturation (0 = no scaling, no rounding)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  x is a new sample this cycle
- x  in  DATA_W  signed input sample
- flush  in  1  clear delay line (pulse)
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(NTAPS)  tap index, 0 = h0 (applied to newest sample)
- coef_data  in  COEF_W  signed coefficient value
- out_valid  out  1  y holds a new result
- y  out  OUT_W  signed filtered output, registered
- out_sat  out  1  y was saturated this result

Behaviour:
- One clock; reset is synchronous and active-low: ports clk and rst_n.
- Reset: delay-line registers, coefficients, y, out_valid and out_sat all cleared to 0.
- ACC_W = DATA_W + COEF_W + clog2(NTAPS). Products and adds are signed at full ACC_W; no intermediate truncation.
- Function: y[n] = sat(round(sum over k=0..NTAPS-1 of h[k]*x[n-k]) >> SHIFT), with n counting accepted samples only.
- Structure is transposed form. State registers S1..S(NTAPS-1) update only on cycles where in_valid=1:
  - S(k) <= h[k]*x + S(k+1)
  - S(NTAPS-1) <= h[NTAPS-1]*x
  - acc = h0*x + S1
- Latency: a sample accepted in cycle t gives out_valid=1 in cycle t+1, with y valid in the same cycle. out_valid is a single-cycle pulse per accepted sample.
- Throughput: one sample per cycle. There is no backpressure; in_valid gaps hold all state unchanged.
- While in_valid=0, y and out_sat hold their last values and out_valid=0.
- Rounding (SHIFT>0): add 2^(SHIFT-1), then arithmetic shift right (round half up).
- Saturation:
  - Result above 2^(OUT_W-1)-1 clamps to 2^(OUT_W-1)-1.
  - Result below -2^(OUT_W-1) clamps to -2^(OUT_W-1).
  - out_sat=1 with that result, otherwise 0.
- Coefficient write: on coef_we=1, h[coef_addr] <= coef_data at the clock edge.
  - A sample accepted in the same cycle uses the OLD coefficient.
  - Products already folded into S registers are not recomputed.
  - A coef_addr >= NTAPS is ignored.
- flush=1: all S registers are cleared at the edge; coefficients, y and out_sat are retained.
  - If in_valid=1 in the same cycle, the sample is discarded (flush wins) and out_valid=0 next cycle.
- Reset mid-stream: a pending out_valid is suppressed and no result is emitted for the in-flight sample.

Test Plan:
1. NTAPS=3, h={1,2,3}, single x=1 then x=0 x3 (in_valid every cycle) -> y=1,2,3,0 on successive out_valid cycles; out_sat=0 throughout.
2. Same setup, x=1 then in_valid low for 5 cycles, then x=0 x2 -> y=1 first, then 2 and 3 after the gap; out_valid asserted only for the 3 accepted samples.
3. h={127,127,127}, x=127 for 3 samples -> third y=32767 with out_sat=1 (true sum 48387). Repeat with x=-128 -> third y=-32768 with out_sat=1.
4. SHIFT=2, h={1,0,0}:
   - x=6 -> y=2
   - x=-6 -> y=-1
   - x=5 -> y=1
5. h={1,1,1}, x=4,4 then flush with in_valid=1 and x=9, then x=1 -> no result for 9; the x=1 sample gives y=1.
6. Write h1=5 in the same cycle as in_valid with x=2 (old h1=0), then x=0 -> second y=0 (old coefficient used); next x=0 after x=2 written under new h1 gives y=10. Separately, assert rst_n=0 mid-stream -> y=0, out_valid=0, and the following impulse with zero coefficients -> y=0.
